// File: rtl/writeback.sv
// Commit stage downstream of execute: drives the register-file write port and
// next-PC, and queues OUT bytes toward the UART, stalling when that queue is full.

module writeback #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic [3:0]           wselector,
    input  logic [31:0]          data,
    input  logic [4:0]           rd_in,
    input  logic [31:0]          pc_in,
    input  logic [31:0]          pc_target,
    output logic                 done,
    output logic [31:0]          pc_next,
    output logic                 reg_we,
    output logic [4:0]           reg_waddr,
    output logic [31:0]          reg_wdata,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [FIFO_AW:0]     fifo_count,
    output logic                 stall
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    localparam logic [FIFO_AW-1:0] PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};
    localparam logic [FIFO_AW:0]   CNT_ONE = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW:0]   CNT_ZERO = {(FIFO_AW+1){1'b0}};

    state_t state_r;
    state_t state_s;

    // operands captured when an OUT commit has to wait for FIFO space
    logic [3:0]  lat_wsel_r;
    logic [31:0] lat_data_r;
    logic [4:0]  lat_rd_r;
    logic [31:0] lat_pc_r;
    logic [31:0] lat_tgt_r;

    logic [3:0]  cur_wsel_s;
    logic [31:0] cur_data_s;
    logic [4:0]  cur_rd_s;
    logic [31:0] cur_pc_s;
    logic [31:0] cur_tgt_s;
    logic        cur_valid_s;

    logic        pop_s;
    logic        full_s;
    logic        allow_s;
    logic        commit_s;
    logic        push_s;
    logic        latch_s;
    logic        tx_valid_s;

    logic [7:0]          mem_r [FIFO_DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_r;
    logic [FIFO_AW-1:0]  rd_ptr_r;
    logic [FIFO_AW:0]    count_r;

    logic        done_r;
    logic [31:0] pc_next_r;
    logic        reg_we_r;
    logic [4:0]  reg_waddr_r;
    logic [31:0] reg_wdata_r;
    logic        stall_r;

    // FIFO status; occupancy equals FIFO_DEPTH exactly when the top count bit is set
    always_comb begin
        tx_valid_s = (count_r != CNT_ZERO);
        full_s     = count_r[FIFO_AW];
        pop_s      = tx_valid_s && tx_ready;
    end

    // operand source select, allow rule and next-state decision
    always_comb begin
        cur_wsel_s  = wselector;
        cur_data_s  = data;
        cur_rd_s    = rd_in;
        cur_pc_s    = pc_in;
        cur_tgt_s   = pc_target;
        cur_valid_s = 1'b0;
        state_s     = state_r;
        case (state_r)
            ST_IDLE: begin
                cur_valid_s = enable;
            end
            ST_STALL: begin
                cur_wsel_s  = lat_wsel_r;
                cur_data_s  = lat_data_r;
                cur_rd_s    = lat_rd_r;
                cur_pc_s    = lat_pc_r;
                cur_tgt_s   = lat_tgt_r;
                cur_valid_s = 1'b1;
            end
            default: begin
                cur_valid_s = 1'b0;
            end
        endcase

        // a same-edge pop frees the slot the push needs
        allow_s  = !cur_wsel_s[3] || !full_s || pop_s;
        commit_s = cur_valid_s && allow_s;
        push_s   = commit_s && cur_wsel_s[3];
        latch_s  = (state_r == ST_IDLE) && enable && !allow_s;

        if (latch_s) begin
            state_s = ST_STALL;
        end else if ((state_r == ST_STALL) && allow_s) begin
            state_s = ST_IDLE;
        end else begin
            state_s = state_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // capture the stalled instruction's operands
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lat_wsel_r <= 4'd0;
            lat_data_r <= 32'd0;
            lat_rd_r   <= 5'd0;
            lat_pc_r   <= 32'd0;
            lat_tgt_r  <= 32'd0;
        end else if (latch_s) begin
            lat_wsel_r <= wselector;
            lat_data_r <= data;
            lat_rd_r   <= rd_in;
            lat_pc_r   <= pc_in;
            lat_tgt_r  <= pc_target;
        end else begin
            lat_wsel_r <= lat_wsel_r;
            lat_data_r <= lat_data_r;
            lat_rd_r   <= lat_rd_r;
            lat_pc_r   <= lat_pc_r;
            lat_tgt_r  <= lat_tgt_r;
        end
    end

    // commit outputs: pulses drop when idle, address/data/PC hold their last value
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done_r      <= 1'b0;
            pc_next_r   <= 32'd0;
            reg_we_r    <= 1'b0;
            reg_waddr_r <= 5'd0;
            reg_wdata_r <= 32'd0;
            stall_r     <= 1'b0;
        end else begin
            stall_r <= (state_s == ST_STALL);
            if (commit_s) begin
                done_r      <= 1'b1;
                pc_next_r   <= cur_wsel_s[2] ? cur_tgt_s : (cur_pc_s + 32'd4);
                reg_we_r    <= cur_wsel_s[1] && (cur_rd_s != 5'd0);
                reg_waddr_r <= cur_rd_s;
                reg_wdata_r <= cur_data_s;
            end else begin
                done_r      <= 1'b0;
                reg_we_r    <= 1'b0;
            end
        end
    end

    // OUT byte storage; no reset needed since entries are only read when valid
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= cur_data_s[7:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {FIFO_AW{1'b0}};
            rd_ptr_r <= {FIFO_AW{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign done       = done_r;
    assign pc_next    = pc_next_r;
    assign reg_we     = reg_we_r;
    assign reg_waddr  = reg_waddr_r;
    assign reg_wdata  = reg_wdata_r;
    assign stall      = stall_r;
    assign tx_valid   = tx_valid_s;
    assign tx_data    = mem_r[rd_ptr_r];
    assign fifo_count = count_r;

    writeback_chk u_chk (
        .clk      (clk),
        .rstn     (rstn),
        .enable   (enable),
        .in_stall (stall_r)
    );

endmodule

// Protocol checker: execute must not offer a new result while commit is stalled.
module writeback_chk (
    input logic clk,
    input logic rstn,
    input logic enable,
    input logic in_stall
);

    a_no_enable_in_stall: assert property (
        @(posedge clk) disable iff (!rstn) !(enable && in_stall)
    ) else $error("enable asserted while writeback is stalled");

endmodule

// File: doc/writeback.md
Name: writeback

Overview:
- Commit stage directly downstream of the execute unit.
- Consumes the execute unit's done pulse, write selector, result data, destination register and branch target.
- Drives the register-file write port and the next-PC value back to fetch.
- Buffers OUT bytes in a small FIFO toward the UART transmitter. Stalls commit when that FIFO is full.

Parameters:
- FIFO_DEPTH, 16, OUT byte FIFO entries; must be a power of two, at least 2.
- FIFO_AW, 4, log2(FIFO_DEPTH); pointer width.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- enable  in  1  one-cycle pulse: execute result valid this cycle
- wselector  in  4  bit1 = write register, bit2 = redirect PC, bit3 = OUT byte; bit0 ignored
- data  in  32  result / OUT value
- rd_in  in  5  destination register
- pc_in  in  32  PC of the committing instruction
- pc_target  in  32  redirect target from execute
- done  out  1  one-cycle pulse: instruction committed
- pc_next  out  32  next fetch PC, valid when done=1
- reg_we  out  1  register-file write enable, one-cycle pulse
- reg_waddr  out  5  register-file write address
- reg_wdata  out  32  register-file write data
- tx_data  out  8  FIFO head byte
- tx_valid  out  1  FIFO non-empty
- tx_ready  in  1  UART accepts head byte
- fifo_count  out  FIFO_AW+1  current FIFO occupancy
- stall  out  1  high while a commit waits for FIFO space

Behaviour:
- Reset (async, rstn=0):
  - done, reg_we, stall = 0.
  - pc_next, reg_waddr, reg_wdata = 0.
  - FIFO read/write pointers and count = 0, so tx_valid = 0.
  - State = IDLE.
  - Reset asserted mid-stall discards the pending commit.
- States: IDLE, STALL.
- IDLE, enable=1, commit allowed → commit at the same edge; outputs appear 1 cycle after the enable cycle.
  - done <= 1.
  - pc_next <= wselector[2] ? pc_target : pc_in + 32'd4, with mod 2^32 wrap.
  - reg_we <= wselector[1] && (rd_in != 0); writes to r0 are suppressed.
  - reg_waddr <= rd_in; reg_wdata <= data.
  - If wselector[3]=1, push data[7:0] into the FIFO.
- Commit allowed when wselector[3]=0, or count < FIFO_DEPTH, or a pop occurs at the same edge (tx_valid && tx_ready).
- IDLE, enable=1, commit not allowed (OUT with a full FIFO and no pop):
  - Latch wselector, data, rd_in, pc_in and pc_target.
  - stall <= 1, done stays 0, state → STALL.
- STALL:
  - Each cycle, re-evaluate the allow rule using the latched operands.
  - When allowed: commit exactly as in IDLE from the latched values, stall <= 0, state → IDLE.
  - enable=1 while in STALL is a protocol violation. It is ignored, and verification flags it with an assertion.
- IDLE, enable=0: done and reg_we return to 0. pc_next and reg_w* hold their last values.
- Multiple selector bits:
  - 0110 (JAL/JALR): register write and redirect in the same commit.
  - 0000 (stores, untaken branch): done with pc_next = pc_in+4 and no writes.
- FIFO:
  - Circular buffer with pointer wrap at FIFO_DEPTH.
  - Pop on tx_valid && tx_ready. tx_data = mem[rd_ptr], stable while tx_valid=1 and not popped.
  - Simultaneous push and pop leaves count unchanged; legal even when full or when count=1.
  - Push into an empty FIFO makes tx_valid 1 on the next cycle; no bypass.
  - count never exceeds FIFO_DEPTH and never underflows.

Test Plan:
- Reset then enable with wselector=0010, rd_in=5, data=32'hDEADBEEF, pc_in=32'h100 → next cycle: done=1, reg_we=1, reg_waddr=5, reg_wdata=32'hDEADBEEF, pc_next=32'h104; following cycle done=0, reg_we=0.
- wselector=0110, rd_in=31, pc_target=32'h2000, pc_in=32'hFFFFFFFC → pc_next=32'h2000, reg_we=1. Repeat with wselector=0000 → pc_next=32'h0 (wrap), reg_we=0. Repeat with wselector=0010, rd_in=0 → reg_we=0, done=1.
- tx_ready=0, issue 16 OUT commits with data 0x41..0x50 → fifo_count=16, no stall. Then raise tx_ready=1 → tx_data sequence 0x41..0x50 in order, tx_valid drops after 16 pops.
- FIFO full, tx_ready=0, OUT with data 0x5A → stall=1, done=0 held for 5 cycles. Raise tx_ready for one cycle → commit on that edge, done=1, stall=0, fifo_count stays 16, last entry 0x5A.
- FIFO full, tx_ready=1 in the same cycle as an OUT enable → no stall, done=1 next cycle, fifo_count unchanged at 16.
- Assert rstn=0 asynchronously (mid-cycle) during STALL with 3 bytes queued → done=0, stall=0, tx_valid=0, fifo_count=0 immediately, without waiting for a clock edge; no commit after release.
